// File: rtl/elastic_pipe.sv
// Elastic FIFO stage between a valid/ready producer and consumer, with optional
// empty-buffer bypass, occupancy flags and a sticky upstream protocol checker.
module elastic_pipe #(
    parameter int DATA_WIDTH   = 32,
    parameter int DEPTH        = 4,
    parameter int FALLTHROUGH  = 0,
    parameter int AFULL_THRESH = DEPTH - 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         soft_rst,
    input  logic                         src_vld,
    output logic                         src_rdy,
    input  logic [DATA_WIDTH-1:0]        src_data,
    output logic                         dst_vld,
    input  logic                         dst_rdy,
    output logic [DATA_WIDTH-1:0]        dst_data,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty,
    output logic                         almost_full,
    output logic                         proto_err
);

    localparam int              CW      = $clog2(DEPTH + 1);
    localparam int              PW      = $clog2(DEPTH);
    localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0]   AFULL_C = CW'(AFULL_THRESH);
    localparam logic [PW-1:0]   LAST_C  = PW'(DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         cnt_q;
    logic                  bypass;
    logic                  push;
    logic                  pop;
    logic                  wr_en;
    logic                  rd_en;
    logic                  stall_q;
    logic [DATA_WIDTH-1:0] stall_data_q;
    logic                  err_q;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == LAST_C) ? '0 : p + PW'(1);
    endfunction

    // Flags and src_rdy come only from the registered count, so dst_rdy never
    // reaches src_rdy combinationally.
    assign count       = cnt_q;
    assign full        = (cnt_q == DEPTH_C);
    assign empty       = (cnt_q == '0);
    assign almost_full = (cnt_q >= AFULL_C);
    assign src_rdy     = ~full;
    assign bypass      = (FALLTHROUGH != 0) && empty;

    always_comb begin
        if (bypass) begin
            dst_vld  = src_vld;
            dst_data = src_data;
        end else begin
            dst_vld  = ~empty;
            dst_data = mem[rd_ptr];
        end
    end

    assign push  = src_vld & src_rdy;
    assign pop   = dst_vld & dst_rdy;
    // A bypassed word that is consumed the same cycle never touches storage.
    assign wr_en = push & ~(bypass & pop);
    assign rd_en = pop & ~bypass;

    // NOTE: all state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else if (soft_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            if (wr_en) wr_ptr <= next_ptr(wr_ptr);
            if (rd_en) rd_ptr <= next_ptr(rd_ptr);
            case ({wr_en, rd_en})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; clearing count and pointers
    // already discards every entry, and a resettable array would not map to RAM.
    always_ff @(posedge clk) begin
        if (wr_en && !soft_rst) mem[wr_ptr] <= src_data;
    end

    // A stalled offer must be held unchanged into the next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q      <= 1'b0;
            stall_data_q <= '0;
            err_q        <= 1'b0;
        end else if (soft_rst) begin
            stall_q      <= 1'b0;
            stall_data_q <= '0;
            err_q        <= 1'b0;
        end else begin
            stall_q      <= src_vld & ~src_rdy;
            stall_data_q <= src_data;
            if (stall_q && (!src_vld || src_data != stall_data_q)) err_q <= 1'b1;
        end
    end

    assign proto_err = err_q;

endmodule

// File: tb/tb_elastic_pipe.sv
// Drives three elastic_pipe configurations with one shared stimulus stream and
// compares each against a queue-based behavioural model every cycle.
module tb_elastic_pipe;

    localparam int NI = 3;
    localparam int DEP [NI] = '{4, 4, 3};
    localparam int FTH [NI] = '{0, 1, 1};
    localparam int AFT [NI] = '{3, 3, 2};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       soft_rst = 1'b0;
    logic       src_vld = 1'b0;
    logic [7:0] src_data = 8'h0;
    logic       dst_rdy = 1'b0;

    logic       src_rdy_o [NI];
    logic       dst_vld_o [NI];
    logic [7:0] dst_data_o [NI];
    logic [2:0] count_o [NI];
    logic       full_o [NI];
    logic       empty_o [NI];
    logic       afull_o [NI];
    logic       perr_o [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        logic [$clog2(DEP[g]+1)-1:0] cnt;
        elastic_pipe #(
            .DATA_WIDTH(8), .DEPTH(DEP[g]), .FALLTHROUGH(FTH[g]), .AFULL_THRESH(AFT[g])
        ) u_dut (
            .clk(clk), .rst_n(rst_n), .soft_rst(soft_rst),
            .src_vld(src_vld), .src_rdy(src_rdy_o[g]), .src_data(src_data),
            .dst_vld(dst_vld_o[g]), .dst_rdy(dst_rdy), .dst_data(dst_data_o[g]),
            .count(cnt), .full(full_o[g]), .empty(empty_o[g]),
            .almost_full(afull_o[g]), .proto_err(perr_o[g])
        );
        assign count_o[g] = 3'(cnt);
    end

    // Reference model: a plain queue of stored words plus the protocol monitor.
    logic [7:0] mq [NI][$];
    bit         m_perr [NI];
    bit         m_stall [NI];
    logic [7:0] m_sdata [NI];

    int         n_vec = 0;
    int         n_err = 0;
    bit         collect = 1'b0;
    bit         acc2 = 1'b0;
    logic [7:0] got2 [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < NI; i++) begin
            mq[i].delete();
            m_perr[i]  = 1'b0;
            m_stall[i] = 1'b0;
            m_sdata[i] = 8'h0;
        end
    endtask

    // One clock cycle: apply inputs, check all outputs, advance the model.
    task automatic step(input bit v, input logic [7:0] d, input bit r, input bit s);
        src_vld  = v;
        src_data = d;
        dst_rdy  = r;
        soft_rst = s;
        #3;
        acc2 = 1'b0;
        for (int i = 0; i < NI; i++) begin
            int         n;
            bit         e_rdy, e_byp, e_vld, psh, pp;
            logic [7:0] e_dat;
            n     = mq[i].size();
            e_rdy = (n < DEP[i]);
            e_byp = (FTH[i] != 0) && (n == 0);
            e_vld = e_byp ? v : (n > 0);
            e_dat = (n > 0) ? mq[i][0] : d;
            check($sformatf("u%0d.count", i), 32'(count_o[i]), 32'(n));
            check($sformatf("u%0d.full", i), 32'(full_o[i]), 32'(n == DEP[i]));
            check($sformatf("u%0d.empty", i), 32'(empty_o[i]), 32'(n == 0));
            check($sformatf("u%0d.almost_full", i), 32'(afull_o[i]), 32'(n >= AFT[i]));
            check($sformatf("u%0d.src_rdy", i), 32'(src_rdy_o[i]), 32'(e_rdy));
            check($sformatf("u%0d.dst_vld", i), 32'(dst_vld_o[i]), 32'(e_vld));
            check($sformatf("u%0d.proto_err", i), 32'(perr_o[i]), 32'(m_perr[i]));
            if (e_vld) check($sformatf("u%0d.dst_data", i), 32'(dst_data_o[i]), 32'(e_dat));
            psh = v && e_rdy;
            pp  = e_vld && r;
            if (s) begin
                mq[i].delete();
                m_perr[i]  = 1'b0;
                m_stall[i] = 1'b0;
            end else begin
                if (m_stall[i] && (!v || d != m_sdata[i])) m_perr[i] = 1'b1;
                m_stall[i] = v && !e_rdy;
                m_sdata[i] = d;
                if (!(e_byp && psh && pp)) begin
                    if (pp) void'(mq[i].pop_front());
                    if (psh) mq[i].push_back(d);
                end
                if (i == 2) begin
                    acc2 = psh;
                    if (collect && pp) got2.push_back(e_dat);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic async_reset();
        rst_n    = 1'b0;
        src_vld  = 1'b0;
        dst_rdy  = 1'b0;
        soft_rst = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) begin
            check($sformatf("u%0d.rst_count", i), 32'(count_o[i]), 32'd0);
            check($sformatf("u%0d.rst_empty", i), 32'(empty_o[i]), 32'd1);
            check($sformatf("u%0d.rst_full", i), 32'(full_o[i]), 32'd0);
            check($sformatf("u%0d.rst_afull", i), 32'(afull_o[i]), 32'd0);
            check($sformatf("u%0d.rst_src_rdy", i), 32'(src_rdy_o[i]), 32'd1);
            check($sformatf("u%0d.rst_dst_vld", i), 32'(dst_vld_o[i]), 32'd0);
            check($sformatf("u%0d.rst_perr", i), 32'(perr_o[i]), 32'd0);
        end
        clear_model();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int  nxt;
        bit  hold;
        async_reset();

        // Fill with downstream stalled, then drain in order.
        for (int k = 1; k <= 4; k++) step(1'b1, 8'(k), 1'b0, 1'b0);
        repeat (5) step(1'b0, 8'h0, 1'b1, 1'b0);

        // Full with a pop and a pending push: pop only, ready returns next cycle.
        for (int k = 5; k <= 8; k++) step(1'b1, 8'(k), 1'b0, 1'b0);
        step(1'b1, 8'h09, 1'b1, 1'b0);
        step(1'b1, 8'h09, 1'b0, 1'b0);
        repeat (6) step(1'b0, 8'h0, 1'b1, 1'b0);
        step(1'b0, 8'h0, 1'b0, 1'b1);

        // Soft reset beats a simultaneous push and pop.
        step(1'b1, 8'h31, 1'b0, 1'b0);
        step(1'b1, 8'h32, 1'b0, 1'b0);
        step(1'b1, 8'h33, 1'b1, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b0);

        // Empty-buffer bypass of one word.
        step(1'b1, 8'hA5, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);

        // Stalled offer changes data: sticky error until soft reset.
        for (int k = 0; k < 4; k++) step(1'b1, 8'(8'h40 + k), 1'b0, 1'b0);
        step(1'b1, 8'h11, 1'b0, 1'b0);
        step(1'b1, 8'h22, 1'b0, 1'b0);
        repeat (3) step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b0);

        // Random traffic with occasional soft resets.
        for (int c = 0; c < 300; c++)
            step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 2) != 0,
                 $urandom_range(0, 49) == 0);

        // Asynchronous reset in the middle of a burst.
        for (int k = 0; k < 3; k++) step(1'b1, 8'(8'hC0 + k), 1'b0, 1'b0);
        async_reset();
        step(1'b0, 8'h00, 1'b1, 1'b0);

        // Ten-word ordered stream through the 3-deep instance, protocol-clean for it.
        step(1'b0, 8'h00, 1'b0, 1'b1);
        collect = 1'b1;
        nxt     = 0;
        hold    = 1'b0;
        for (int c = 0; c < 400 && got2.size() < 10; c++) begin
            bit v;
            v = (nxt < 10) && (hold || $urandom_range(0, 1) == 1);
            step(v, 8'(nxt), $urandom_range(0, 1) == 1, 1'b0);
            hold = v && !acc2;
            if (acc2) nxt++;
        end
        collect = 1'b0;
        check("u2.stream_len", 32'(got2.size()), 32'd10);
        for (int j = 0; j < got2.size(); j++)
            check($sformatf("u2.stream[%0d]", j), 32'(got2[j]), 32'(j));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/elastic_pipe.md
ELASTIC_PIPE -- requirements
Module: elastic_pipe

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, payload width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, storage entries; legal range 2..256, power of two not required.
REQ-003 SHALL have parameter FALLTHROUGH, default 0; 1 = empty-buffer bypass, 0 = registered output.
REQ-004 SHALL have parameter AFULL_THRESH, default DEPTH-1, almost-full level; legal range 1..DEPTH.
REQ-005 SHALL have port clk  input  1  clock; all state on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port soft_rst  input  1  synchronous clear, active-high.
REQ-008 SHALL have port src_vld  input  1  upstream valid.
REQ-009 SHALL have port src_rdy  output  1  upstream ready.
REQ-010 SHALL have port src_data  input  DATA_WIDTH  upstream payload.
REQ-011 SHALL have port dst_vld  output  1  downstream valid.
REQ-012 SHALL have port dst_rdy  input  1  downstream ready.
REQ-013 SHALL have port dst_data  output  DATA_WIDTH  downstream payload.
REQ-014 SHALL have port count  output  $clog2(DEPTH+1)  stored entries, 0..DEPTH.
REQ-015 SHALL have port full / empty / almost_full  output  1 each  occupancy flags.
REQ-016 SHALL have port proto_err  output  1  sticky upstream protocol-violation flag.

Function
REQ-017 SHALL define push = src_vld & src_rdy, pop = dst_vld & dst_rdy; a transfer occurs only on push/pop.
REQ-018 SHALL store entries in a DEPTH-entry circular buffer with write and read pointers wrapping DEPTH-1 -> 0.
REQ-019 SHALL drive src_rdy = ~full, from registered state only; no combinational path dst_rdy -> src_rdy.
REQ-020 SHALL drive full = (count == DEPTH), empty = (count == 0), almost_full = (count >= AFULL_THRESH), all from registered count.
REQ-021 SHALL update count per cycle: push only +1, pop from storage only -1, both or neither unchanged.
REQ-022 SHALL, when full, refuse push even if pop occurs that cycle; src_rdy rises the cycle after the pop.
REQ-023 SHALL, with FALLTHROUGH=0, drive dst_vld = ~empty and dst_data = oldest entry; push-to-dst_vld latency one cycle.
REQ-024 SHALL, with FALLTHROUGH=1 and empty, drive dst_vld = src_vld and dst_data = src_data (zero latency).
REQ-025 SHALL, with FALLTHROUGH=1, empty and push & pop same cycle, pass the word through without storing; count stays 0.
REQ-026 SHALL, with FALLTHROUGH=1 and not empty, behave exactly as FALLTHROUGH=0.
REQ-027 SHALL preserve strict FIFO order across pointer wrap-around and all push/pop interleavings.
REQ-028 SHALL hold dst_vld and dst_data stable while dst_vld=1 and dst_rdy=0.
REQ-029 SHALL leave dst_data value unspecified while dst_vld=0; bench does not check it.
REQ-030 SHALL set proto_err when src_vld=1 & src_rdy=0 in cycle n and, in cycle n+1, src_vld=0 or src_data differs.
REQ-031 SHALL keep proto_err set until rst_n or soft_rst; it does not affect data flow.

Reset
REQ-032 SHALL on rst_n low force asynchronously: count=0, pointers=0, empty=1, full=0, almost_full=0, src_rdy=1, dst_vld=0 (FALLTHROUGH=0), proto_err=0.
REQ-033 SHALL on soft_rst=1 at a clock edge apply REQ-032 values synchronously, with priority over push and pop that cycle.
REQ-034 SHALL discard all stored entries on either reset, including mid-burst; storage contents need not be cleared.

Verification
REQ-035 SHALL cover: DEPTH=4, FALLTHROUGH=0, push 1,2,3,4 with dst_rdy=0 -> count=4, full=1, src_rdy=0, almost_full=1 from count=3; then dst_rdy=1 -> 1,2,3,4 out in order.
REQ-036 SHALL cover: full and src_vld=1, dst_rdy=1 one cycle -> word popped, no push, count=3; src_rdy=1 next cycle.
REQ-037 SHALL cover: FALLTHROUGH=1, empty, src_vld=1 data 0xA5, dst_rdy=1 -> dst_vld=1, dst_data=0xA5 same cycle, count stays 0.
REQ-038 SHALL cover: DEPTH=3, 10 words 0..9, random src_vld/dst_rdy -> output sequence 0..9, no loss or duplication across wrap.
REQ-039 SHALL cover: count=2, soft_rst=1 with push and pop active -> next cycle count=0, empty=1, dst_vld=0, nothing transferred.
REQ-040 SHALL cover: full, src_vld=1 data 0x11, next cycle data 0x22 -> proto_err=1, stays 1 until soft_rst.
